sd2vc_mchan: RTL and testbench

//  Multi-channel srdy/drdy to valid/credit converter. Merges `channels` srdy/drdy

---
 rtl/sd2vc_mchan.sv | 111 +++++++++++
 tb/tb_sd2vc_mchan.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sd2vc_mchan.sv
// Multi-channel srdy/drdy to valid/credit converter with per-VC credit counters
// and a round-robin arbiter; all link outputs are registered.
module sd2vc_mchan #(
   parameter int width    = 8,
   parameter int channels = 4,
   parameter int vc_sz    = 2,
   parameter int cc_sz    = 3,
   parameter int init_cr  = 0,
   parameter int reginp   = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [channels-1:0]       c_srdy,
   output logic [channels-1:0]       c_drdy,
   input  logic [channels*width-1:0] c_data,
   output logic                      p_vld,
   output logic [vc_sz-1:0]          p_vc,
   output logic [width-1:0]          p_data,
   input  logic [channels-1:0]       p_cr,
   output logic                      cr_ovf
);

   localparam logic [cc_sz-1:0] CC_MAX  = '1;
   localparam logic [cc_sz-1:0] CC_INIT = cc_sz'(init_cr);
   localparam logic [vc_sz:0]   NCH     = (vc_sz+1)'(channels);

   logic [cc_sz-1:0]      cc [channels];
   logic [vc_sz-1:0]      rr_ptr;
   logic [channels-1:0]   in_cr;
   logic [channels-1:0]   elig;
   logic [channels-1:0]   grant;
   logic [channels-1:0]   drop;
   logic [channels-1:0]   rot;
   logic [2*channels-1:0] dbl;
   logic [vc_sz:0]        off;
   logic [vc_sz:0]        sum;
   logic [vc_sz-1:0]      gnt_idx;
   logic [vc_sz-1:0]      nxt_ptr;
   logic                  found;
   logic [width-1:0]      sel_data;

   if (reginp != 0) begin : g_cr_reg
      logic [channels-1:0] cr_q;
      always_ff @(posedge clk or posedge reset) begin
         if (reset) cr_q <= '0;
         else       cr_q <= p_cr;
      end
      assign in_cr = cr_q;
   end else begin : g_cr_dir
      assign in_cr = p_cr;
   end

   always_comb begin
      for (int i = 0; i < channels; i++) begin
         elig[i] = c_srdy[i] & (cc[i] != '0);
      end
   end

   // Rotate so bit 0 is the channel at rr_ptr; first set bit is the winner.
   assign dbl = {elig, elig} >> rr_ptr;
   assign rot = dbl[channels-1:0];

   always_comb begin
      off = '0;
      for (int j = channels - 1; j >= 0; j--) begin
         if (rot[j]) off = j[vc_sz:0];
      end
      sum = {1'b0, rr_ptr} + off;
      if (sum >= NCH) sum = sum - NCH;
      found   = |rot;
      gnt_idx = sum[vc_sz-1:0];
      nxt_ptr = (sum == NCH - 1'b1) ? '0 : gnt_idx + 1'b1;
      grant   = '0;
      if (found) grant[gnt_idx] = 1'b1;
   end

   assign c_drdy   = grant;
   assign sel_data = c_data[gnt_idx*width +: width];

   always_comb begin
      for (int i = 0; i < channels; i++) begin
         drop[i] = in_cr[i] & ~grant[i] & (cc[i] == CC_MAX);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < channels; i++) cc[i] <= CC_INIT;
         rr_ptr <= '0;
         p_vld  <= 1'b0;
         p_vc   <= '0;
         p_data <= '0;
         cr_ovf <= 1'b0;
      end else begin
         for (int i = 0; i < channels; i++) begin
            if (grant[i] & ~in_cr[i])
               cc[i] <= cc[i] - 1'b1;
            else if (in_cr[i] & ~grant[i] & (cc[i] != CC_MAX))
               cc[i] <= cc[i] + 1'b1;
         end
         p_vld  <= found;
         cr_ovf <= |drop;
         if (found) begin
            p_vc   <= gnt_idx;
            p_data <= sel_data;
            rr_ptr <= nxt_ptr;
         end
      end
   end

endmodule

// File: tb/tb_sd2vc_mchan.sv
// Directed bench for sd2vc_mchan: several instances cover init_cr, reginp,
// and a non-power-of-two channel count.
module tb_sd2vc_mchan;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rst_r = 1'b1;
   always #5 clk = ~clk;

   logic [3:0]  s0, s2, s7, sr, cr0, cr2, cr7, crr, d0, d2, d7, dr;
   logic [2:0]  s3, cr3, d3;
   logic [31:0] da0, da2, da7, dar;
   logic [23:0] da3;
   logic        v0, v2, v3, v7, vr, o0, o2, o3, o7, orr;
   logic [1:0]  vc0, vc2, vc3, vc7, vcr;
   logic [7:0]  pd0, pd2, pd3, pd7, pdr;

   int passed = 0;
   int fails = 0;
   int total = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   sd2vc_mchan #(.init_cr(0)) u0 (
      .clk(clk), .reset(reset), .c_srdy(s0), .c_drdy(d0), .c_data(da0),
      .p_vld(v0), .p_vc(vc0), .p_data(pd0), .p_cr(cr0), .cr_ovf(o0));

   sd2vc_mchan #(.init_cr(2)) u2 (
      .clk(clk), .reset(reset), .c_srdy(s2), .c_drdy(d2), .c_data(da2),
      .p_vld(v2), .p_vc(vc2), .p_data(pd2), .p_cr(cr2), .cr_ovf(o2));

   sd2vc_mchan #(.init_cr(7)) u7 (
      .clk(clk), .reset(reset), .c_srdy(s7), .c_drdy(d7), .c_data(da7),
      .p_vld(v7), .p_vc(vc7), .p_data(pd7), .p_cr(cr7), .cr_ovf(o7));

   sd2vc_mchan #(.channels(3), .init_cr(2)) u3 (
      .clk(clk), .reset(reset), .c_srdy(s3), .c_drdy(d3), .c_data(da3),
      .p_vld(v3), .p_vc(vc3), .p_data(pd3), .p_cr(cr3), .cr_ovf(o3));

   sd2vc_mchan #(.init_cr(2), .reginp(1)) ur (
      .clk(clk), .reset(rst_r), .c_srdy(sr), .c_drdy(dr), .c_data(dar),
      .p_vld(vr), .p_vc(vcr), .p_data(pdr), .p_cr(crr), .cr_ovf(orr));

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      s0 = '0; s2 = '0; s7 = '0; sr = '0; s3 = '0;
      cr0 = '0; cr2 = '0; cr7 = '0; crr = '0; cr3 = '0;
      da0 = 32'hDEADBEEF; da2 = '0; da7 = 32'h33221100;
      dar = 32'h44332211; da3 = 24'h221100;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      rst_r = 1'b0;

      chk("rst_vld", v0, 0);
      chk("rst_vc", vc0, 0);
      chk("rst_data", pd0, 0);
      chk("rst_ovf", o7, 0);
      chk("rst_vld_r", vr, 0);

      // No credits: nothing may ever be granted
      s0 = 4'hF;
      for (int k = 0; k < 4; k++) begin
         #1 chk("t1_drdy", d0, 0);
         @(negedge clk);
         chk("t1_vld", v0, 0);
         chk("t1_vc", vc0, 0);
      end

      // Two initial credits on channel 1, then one returned credit
      s2 = 4'b0010; da2[15:8] = 8'hA1;
      #1 chk("t2_drdy_a", d2, 4'b0010);
      @(negedge clk);
      chk("t2_vld_a", v2, 1);
      chk("t2_vc_a", vc2, 1);
      chk("t2_data_a", pd2, 8'hA1);
      da2[15:8] = 8'hA2;
      #1 chk("t2_drdy_b", d2, 4'b0010);
      @(negedge clk);
      chk("t2_vld_b", v2, 1);
      chk("t2_data_b", pd2, 8'hA2);
      da2[15:8] = 8'hA3;
      #1 chk("t2_stall", d2, 0);
      @(negedge clk);
      chk("t2_idle", v2, 0);
      chk("t2_hold_vc", vc2, 1);
      chk("t2_hold_data", pd2, 8'hA2);
      cr2 = 4'b0010;
      #1 chk("t2_same_cyc", d2, 0);
      @(negedge clk);
      cr2 = '0;
      chk("t2_idle2", v2, 0);
      #1 chk("t2_drdy_c", d2, 4'b0010);
      @(negedge clk);
      chk("t2_vld_c", v2, 1);
      chk("t2_data_c", pd2, 8'hA3);
      #1 chk("t2_stall2", d2, 0);
      s2 = '0;
      @(negedge clk);
      chk("t2_end", v2, 0);

      // Grant and credit return on the same channel in the same cycle
      s2 = 4'b0100; da2[23:16] = 8'hC1;
      #1 chk("t4_drdy_a", d2, 4'b0100);
      @(negedge clk);
      chk("t4_vc_a", vc2, 2);
      chk("t4_data_a", pd2, 8'hC1);
      da2[23:16] = 8'hC2; cr2 = 4'b0100;
      #1 chk("t4_drdy_b", d2, 4'b0100);
      @(negedge clk);
      cr2 = '0;
      chk("t4_data_b", pd2, 8'hC2);
      da2[23:16] = 8'hC3;
      #1 chk("t4_drdy_c", d2, 4'b0100);
      @(negedge clk);
      chk("t4_vld_c", v2, 1);
      chk("t4_data_c", pd2, 8'hC3);
      #1 chk("t4_stall", d2, 0);
      s2 = '0;
      @(negedge clk);
      chk("t4_end", v2, 0);

      // Credit returned to a saturated counter
      cr7 = 4'b0001;
      @(negedge clk);
      cr7 = '0;
      chk("t5_ovf", o7, 1);
      @(negedge clk);
      chk("t5_ovf_clr", o7, 0);

      // Round-robin across four channels with seven credits each
      s7 = 4'hF;
      #1 chk("t3_drdy0", d7, 4'b0001);
      for (int b = 0; b < 28; b++) begin
         @(negedge clk);
         chk("t3_vld", v7, 1);
         chk("t3_vc", vc7, b % 4);
         chk("t3_data", pd7, (b % 4) * 8'h11);
         if (b < 27) chk("t3_drdy", d7, 1 << ((b + 1) % 4));
         else        chk("t3_drdy_last", d7, 0);
      end
      @(negedge clk);
      chk("t3_end", v7, 0);
      s7 = '0;

      // Three channels: pointer wraps at 3
      s3 = 3'b111;
      #1 chk("t7_drdy0", d3, 3'b001);
      for (int b = 0; b < 6; b++) begin
         @(negedge clk);
         chk("t7_vld", v3, 1);
         chk("t7_vc", vc3, b % 3);
         chk("t7_data", pd3, (b % 3) * 8'h11);
      end
      @(negedge clk);
      chk("t7_end", v3, 0);
      chk("t7_drdy_end", d3, 0);
      s3 = '0;

      // Registered credit input adds one cycle of credit latency
      sr = 4'b1000;
      #1 chk("t6_drdy_a", dr, 4'b1000);
      @(negedge clk);
      @(negedge clk);
      chk("t6_vld_b", vr, 1);
      chk("t6_vc_b", vcr, 3);
      #1 chk("t6_stall", dr, 0);
      crr = 4'b1000;
      @(negedge clk);
      crr = '0;
      #1 chk("t6_late1", dr, 0);
      @(negedge clk);
      chk("t6_idle", vr, 0);
      #1 chk("t6_late2", dr, 4'b1000);
      @(negedge clk);
      chk("t6_vld_c", vr, 1);
      chk("t6_vc_c", vcr, 3);

      // Reset in the middle of a burst
      sr = 4'hF;
      @(negedge clk);
      chk("t6_burst", vr, 1);
      chk("t6_burst_vc", vcr, 0);
      #2 rst_r = 1'b1;
      #1;
      chk("t6_rst_vld", vr, 0);
      chk("t6_rst_vc", vcr, 0);
      chk("t6_rst_data", pdr, 0);
      @(negedge clk);
      rst_r = 1'b0;
      for (int b = 0; b < 8; b++) begin
         @(negedge clk);
         chk("t6_re_vld", vr, 1);
         chk("t6_re_vc", vcr, b % 4);
         chk("t6_re_data", pdr, (b % 4) * 8'h11 + 8'h11);
      end
      @(negedge clk);
      chk("t6_re_end", vr, 0);
      sr = '0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
